// File: rtl/ps2_keypad.sv
// PS/2 keyboard receiver and scan-code set 2 decoder driving the CHIP-8 16-key hex keypad.
// Raw PS/2 lines are synchronised and glitch-filtered, and frames are sampled on filtered clock falls.
module ps2_keypad #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        CLK_25MHZ,
  input  logic        RESET_N,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  output logic [15:0] KEYS,
  output logic        KEY_EVENT,
  output logic [3:0]  KEY_CODE,
  output logic        KEY_PRESSED,
  output logic        FRAME_ERROR
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Returns {hit, key index} for a scan code.
  function automatic logic [4:0] map_key(input logic [7:0] sc);
    logic [4:0] r;
    case (sc)
      8'h16:   r = 5'h11;
      8'h1E:   r = 5'h12;
      8'h26:   r = 5'h13;
      8'h25:   r = 5'h1C;
      8'h15:   r = 5'h14;
      8'h1D:   r = 5'h15;
      8'h24:   r = 5'h16;
      8'h2D:   r = 5'h1D;
      8'h1C:   r = 5'h17;
      8'h1B:   r = 5'h18;
      8'h23:   r = 5'h19;
      8'h2B:   r = 5'h1E;
      8'h1A:   r = 5'h1A;
      8'h22:   r = 5'h10;
      8'h21:   r = 5'h1B;
      8'h2A:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          fclk_q;
  logic          fdat_q;
  logic          fclk_dly_q;
  logic [FW-1:0] fclk_cnt_q;
  logic [FW-1:0] fdat_cnt_q;
  logic          fclk_fall;

  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DATA};
    end
  end

  // A filtered level flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      fclk_q     <= 1'b1;
      fdat_q     <= 1'b1;
      fclk_dly_q <= 1'b1;
      fclk_cnt_q <= '0;
      fdat_cnt_q <= '0;
    end else begin
      fclk_dly_q <= fclk_q;
      if (clk_sync_q[1] == fclk_q) begin
        fclk_cnt_q <= '0;
      end else if (fclk_cnt_q == FILT_MAX) begin
        fclk_q     <= clk_sync_q[1];
        fclk_cnt_q <= '0;
      end else begin
        fclk_cnt_q <= fclk_cnt_q + FW'(1);
      end
      if (dat_sync_q[1] == fdat_q) begin
        fdat_cnt_q <= '0;
      end else if (fdat_cnt_q == FILT_MAX) begin
        fdat_q     <= dat_sync_q[1];
        fdat_cnt_q <= '0;
      end else begin
        fdat_cnt_q <= fdat_cnt_q + FW'(1);
      end
    end
  end

  assign fclk_fall = fclk_dly_q & ~fclk_q;

  rx_state_t     state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bitcnt_q;
  logic          par_q;
  logic [TW-1:0] tcnt_q;
  logic          byte_valid_q;
  logic          bad_frame_q;
  logic          frame_err_q;

  // Frame errors travel through bad_frame_q to align with decoded-key latency;
  // a timeout sets the output register directly.
  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bitcnt_q     <= '0;
      par_q        <= 1'b0;
      tcnt_q       <= '0;
      byte_valid_q <= 1'b0;
      bad_frame_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      bad_frame_q  <= 1'b0;
      frame_err_q  <= bad_frame_q;
      if (fclk_fall) begin
        tcnt_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (!fdat_q) begin
              state_q  <= ST_DATA;
              bitcnt_q <= '0;
            end else begin
              bad_frame_q <= 1'b1;
            end
          end
          ST_DATA: begin
            shift_q  <= {fdat_q, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            par_q   <= fdat_q;
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (fdat_q && (^{shift_q, par_q})) byte_valid_q <= 1'b1;
            else                              bad_frame_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q == ST_IDLE) begin
        tcnt_q <= '0;
      end else if (tcnt_q == TOUT_MAX) begin
        state_q     <= ST_IDLE;
        tcnt_q      <= '0;
        frame_err_q <= 1'b1;
      end else begin
        tcnt_q <= tcnt_q + TW'(1);
      end
    end
  end

  logic        brk_q;
  logic        ext_q;
  logic [15:0] keys_q;
  logic        evt_q;
  logic [3:0]  code_q;
  logic        pressed_q;
  logic [4:0]  map_w;
  logic        map_hit;
  logic [3:0]  map_idx;

  assign map_w   = map_key(shift_q);
  assign map_hit = map_w[4];
  assign map_idx = map_w[3:0];

  // Prefix bytes arm the flags; any other accepted byte consumes and clears them.
  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      keys_q    <= '0;
      evt_q     <= 1'b0;
      code_q    <= '0;
      pressed_q <= 1'b0;
    end else begin
      evt_q <= 1'b0;
      if (byte_valid_q) begin
        if (shift_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else if (shift_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else begin
          brk_q <= 1'b0;
          ext_q <= 1'b0;
          if (!ext_q && map_hit && (keys_q[map_idx] == brk_q)) begin
            keys_q[map_idx] <= ~brk_q;
            evt_q           <= 1'b1;
            code_q          <= map_idx;
            pressed_q       <= ~brk_q;
          end
        end
      end
    end
  end

  assign KEYS        = keys_q;
  assign KEY_EVENT   = evt_q;
  assign KEY_CODE    = code_q;
  assign KEY_PRESSED = pressed_q;
  assign FRAME_ERROR = frame_err_q;

endmodule

// File: doc/ps2_keypad.md
Name: ps2_keypad

Overview:
- PS/2 keyboard front end that feeds the CHIP-8 core's 16-key hex keypad.
- Receives raw PS/2 device-to-host frames from the Arduino header pins and decodes scan-code set 2 make/break sequences.
- Maintains a live 16-bit pressed-key vector and issues one strobe per key state change.
- Sits directly upstream of the CHIP-8 keypad/instruction logic, in the 25 MHz video clock domain.

Parameters:
- FILTER_LEN, 8: consecutive identical samples required before the filtered PS2_CLK/PS2_DATA level changes.
- TIMEOUT_CYCLES, 50000: maximum cycles between filtered clock falling edges inside a frame (2 ms at 25 MHz).

Ports:
- CLK_25MHZ  in  1  system clock, 25 MHz.
- RESET_N  in  1  asynchronous active-low reset.
- PS2_CLK  in  1  raw PS/2 clock, asynchronous to CLK_25MHZ.
- PS2_DATA  in  1  raw PS/2 data, asynchronous.
- KEYS  out  16  bit k = 1 while CHIP-8 key k is held.
- KEY_EVENT  out  1  one-cycle strobe on any KEYS bit change.
- KEY_CODE  out  4  index of the changed key; valid while KEY_EVENT is high, holds its value otherwise.
- KEY_PRESSED  out  1  1 = press, 0 = release; valid with KEY_EVENT.
- FRAME_ERROR  out  1  one-cycle strobe on a parity, start, stop, or timeout error.

Behaviour:
- Interface: one clock, CLK_25MHZ; reset RESET_N, asynchronous, active-low.
- Reset values: all outputs 0; receiver state IDLE; break and extended flags 0; filtered lines 1; sync flops 1.
- Input conditioning:
  - 2-flop synchroniser on each input.
  - Filter: a filtered line takes a new level only after FILTER_LEN consecutive equal synchronised samples.
  - A falling edge of the filtered clock defines a sample point, fclk_fall.
- Receiver FSM, advanced only on fclk_fall:
  - IDLE: data=0 → DATA with bit count 0. data=1 → stay in IDLE and pulse FRAME_ERROR.
  - DATA: shift data in LSB first; after 8 bits → PARITY.
  - PARITY: capture bit → STOP.
  - STOP: if data=1 and the XOR of the 8 data bits plus parity = 1 (odd parity), emit byte_valid. Otherwise pulse FRAME_ERROR. Always return to IDLE.
- Timeout:
  - Counter clears on every fclk_fall and in IDLE.
  - In any non-IDLE state, reaching TIMEOUT_CYCLES-1 forces IDLE, discards the partial byte, and pulses FRAME_ERROR.
- Decoder, acting on byte_valid:
  - 0xF0: set brk.
  - 0xE0: set ext.
  - Any other byte with ext=1: ignore the byte; clear brk and ext.
  - Any other byte with ext=0: look it up in the key map, then clear brk and ext.
  - Mapped byte: new level = !brk. Write KEYS[k] only if the level differs from the current KEYS[k]; in that case pulse KEY_EVENT with KEY_CODE=k and KEY_PRESSED=!brk.
  - Typematic repeats and duplicate breaks produce no event.
  - Unmapped codes, including 0xAA and 0xFA: no effect except clearing the flags.
  - A byte rejected for parity, stop, or timeout leaves brk and ext unchanged.
- Key map (scan code → key):
  - 16→1, 1E→2, 26→3, 25→C
  - 15→4, 1D→5, 24→6, 2D→D
  - 1C→7, 1B→8, 23→9, 2B→E
  - 1A→A, 22→0, 21→B, 2A→F
- Latency:
  - KEYS, KEY_EVENT, KEY_CODE, and KEY_PRESSED update exactly 2 cycles after the fclk_fall that samples the stop bit.
  - A FRAME_ERROR caused by a bad frame follows the same 2-cycle latency. A timeout FRAME_ERROR occurs 1 cycle after the count is reached.
- Simultaneous events: only one byte completes per frame, so at most one KEY_EVENT occurs per stop-bit edge. A timeout and an fclk_fall in the same cycle: the edge wins and the counter clears.
- Reset mid-frame: asynchronous clear of everything, including KEYS. The next frame is accepted only when it starts with a clean start bit.

Test Plan:
- Frame 0x16 (odd parity, bit period 80 µs) → KEYS=0x0002; one KEY_EVENT, KEY_CODE=1, KEY_PRESSED=1, exactly 2 cycles after the stop edge. Then F0,16 → KEYS=0x0000, event with KEY_PRESSED=0.
- 0x22 sent three times (typematic) → KEYS=0x0001, exactly one KEY_EVENT. Then F0,22 twice → one release event only.
- Frame 0x1A with wrong parity → FRAME_ERROR pulse, KEYS unchanged. F0 followed by a bad-parity frame, then 1A → break still pending, no event.
- E0,75 and E0,F0,75, then 2A → no events from the extended sequences; the 2A gives KEY_CODE=F, KEYS=0x8000.
- Data stops after 4 bits for 3 ms → FRAME_ERROR pulse, FSM in IDLE. Then a valid 0x1E → KEY_CODE=2 press.
- A 5-cycle low glitch on PS2_CLK is ignored (no bit shifted). RESET_N low mid-frame with KEYS=0x0010 → all outputs 0 immediately; the following frame 0x25 decodes to KEY_CODE=C.
